// File: rtl/pwm_motor_timer.sv
// pwm_motor_timer
//   Motor PWM timer/controller: switch-selected duty PWM, direction output with a forced
//   dead time before any direction change, latched overcurrent fault, and the free-running
//   TCR.E square wave that steps the 7-segment digit select.
module pwm_motor_timer #(
    parameter int PERIOD       = 100000, // CLK cycles per PWM period, multiple of 2**DUTY_W
    parameter int CNT_W        = 17,     // period counter width, 2**CNT_W >= PERIOD
    parameter int DUTY_W       = 4,      // duty request width
    parameter int DEAD_PERIODS = 8       // PWM periods of forced-off time on direction change
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic              SW7,
    input  logic              SnsA,
    input  logic [DUTY_W-1:0] Duty,
    output logic              PWM,
    output logic              DIR,
    output logic              E,
    output logic              Fault,
    output logic [1:0]        State
);

    localparam int STEP   = PERIOD / (2 ** DUTY_W);
    localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Two-stage synchronizers: bit 0 is the metastable stage, bit 1 is the usable value
    logic [1:0]        r_en_sync;
    logic [1:0]        r_sw7_sync;
    logic [1:0]        r_sns_sync;

    logic [CNT_W-1:0]  r_cnt;
    logic [DUTY_W-1:0] r_duty_q;
    logic [DEAD_W-1:0] r_dead_cnt;
    state_t            r_state;
    logic              r_pwm;
    logic              r_dir;
    logic              r_e;
    logic              r_fault;

    logic              w_en;
    logic              w_sw7;
    logic              w_sns;
    logic              w_wrap;
    logic              w_dir_req;
    logic [CNT_W-1:0]  w_on_cycles;

    assign w_en        = r_en_sync[1];
    assign w_sw7       = r_sw7_sync[1];
    assign w_sns       = r_sns_sync[1];
    assign w_wrap      = (r_cnt == CNT_W'(PERIOD - 1));
    assign w_dir_req   = (w_sw7 != r_dir);
    assign w_on_cycles = CNT_W'(r_duty_q) * CNT_W'(STEP);

    // Bring the asynchronous switch and sense inputs into the CLK domain
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_en_sync  <= '0;
            r_sw7_sync <= '0;
            r_sns_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage capture the previous stage's old
            // value, which is what makes this a two-flop chain rather than a single wire.
            r_en_sync  <= {r_en_sync[0],  Enable};
            r_sw7_sync <= {r_sw7_sync[0], SW7};
            r_sns_sync <= {r_sns_sync[0], SnsA};
        end
    end

    // Free-running period counter, runs in every state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Duty is sampled only at the period boundary so a pulse in flight is never reshaped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_duty_q <= '0;
        end else if (w_wrap) begin
            r_duty_q <= Duty;
        end
    end

    // Registered PWM and display square wave, both derived from the period counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pwm <= 1'b0;
            r_e   <= 1'b0;
        end else begin
            r_pwm <= (r_state == ST_RUN) && (r_cnt < w_on_cycles);
            r_e   <= (r_cnt < CNT_W'(PERIOD / 2));
        end
    end

    // Control FSM: fault has top priority, then enable, then direction/dead-time handling
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_dir      <= 1'b0;
            r_fault    <= 1'b0;
            r_dead_cnt <= '0;
        end else if (w_sns) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
        end else begin
            unique case (r_state)
                ST_FAULT: begin
                    // Sense is known clear here; leave only once the operator drops Enable
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // Start on a period boundary so the first pulse is a full one
                    if (w_en && w_wrap) begin
                        if (w_dir_req) begin
                            r_state    <= ST_DEAD;
                            r_dead_cnt <= DEAD_W'(DEAD_PERIODS);
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_dir_req) begin
                        r_state    <= ST_DEAD;
                        r_dead_cnt <= DEAD_W'(DEAD_PERIODS);
                    end
                end
                ST_DEAD: begin
                    // Count whole periods; further SW7 activity does not restart the count
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_wrap) begin
                        r_dead_cnt <= r_dead_cnt - DEAD_W'(1);
                        if (r_dead_cnt == DEAD_W'(1)) begin
                            r_dir   <= w_sw7;
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign PWM   = r_pwm;
    assign DIR   = r_dir;
    assign E     = r_e;
    assign Fault = r_fault;
    assign State = r_state;

endmodule

// File: tb/tb_pwm_motor_timer.sv
// tb_pwm_motor_timer
//   Directed sequence with randomized duty values, change points and toggle phases.
//   Expected values come from a time-based model: n counts clock edges since reset release,
//   so the counter value, the square wave and the ideal pulse shape follow from arithmetic on n.
module tb_pwm_motor_timer;

    localparam int PERIOD       = 160;
    localparam int CNT_W        = 8;
    localparam int DUTY_W       = 4;
    localparam int DEAD_PERIODS = 3;
    localparam int STEP         = PERIOD / (2 ** DUTY_W);

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DEAD  = 2;
    localparam int S_FAULT = 3;

    logic              CLK    = 1'b0;
    logic              RST    = 1'b1;
    logic              Enable = 1'b0;
    logic              SW7    = 1'b0;
    logic              SnsA   = 1'b0;
    logic [DUTY_W-1:0] Duty   = 4'd4;
    logic              PWM;
    logic              DIR;
    logic              E;
    logic              Fault;
    logic [1:0]        State;

    int checks = 0;
    int errors = 0;
    int n      = 0;   // clock edges since reset release
    int cur    = 0;   // duty value latched for the upcoming period

    pwm_motor_timer #(
        .PERIOD      (PERIOD),
        .CNT_W       (CNT_W),
        .DUTY_W      (DUTY_W),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Enable(Enable),
        .SW7   (SW7),
        .SnsA  (SnsA),
        .Duty  (Duty),
        .PWM   (PWM),
        .DIR   (DIR),
        .E     (E),
        .Fault (Fault),
        .State (State)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Square wave: high while the counter value before the last edge was in the first half
    function automatic logic exp_e();
        return (n > 0) && (((n - 1) % PERIOD) < PERIOD / 2);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (!RST) n++;
        check("E_wave", E, exp_e());
    endtask

    // One full period in RUN starting right after a wrap; optional mid-period duty change
    task automatic measure_period(input int exp_duty, input int change_at, input int new_duty);
        int hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            check("PWM_shape", PWM, (((n - 1) % PERIOD) < exp_duty * STEP));
            if (PWM === 1'b1) hi++;
            if (i == change_at) Duty = DUTY_W'(new_duty);
        end
        check("PWM_on_cycles", hi, exp_duty * STEP);
    endtask

    // Request a direction change from RUN and follow the dead time to its end
    task automatic dead_episode(input logic new_dir, input bit glitch);
        int  q    = n % PERIOD;
        int  dead = 0;
        bit  done = 0;
        SW7 = new_dir;
        for (int t = 1; t <= 5 * PERIOD; t++) begin
            tick();
            if (t == 4) begin
                check("pwm_off_after_toggle", PWM, 0);
                check("dead_entered", State, S_DEAD);
            end
            if (glitch && t == 200) SW7 = !new_dir;
            if (glitch && t == 210) SW7 = new_dir;
            if (State === 2'(S_DEAD)) begin
                dead++;
            end else if (t > 4) begin
                done = 1;
                break;
            end
        end
        check("dead_exit_seen", done, 1);
        // Entry 3 edges after the toggle; exit on the DEAD_PERIODS-th wrap after entry
        check("dead_cycles", dead, (PERIOD - ((q + 3) % PERIOD)) + (DEAD_PERIODS - 1) * PERIOD);
        check("dead_exit_at_wrap", n % PERIOD, 0);
        check("dir_at_exit", DIR, new_dir);
        check("state_after_dead", State, S_RUN);
    endtask

    initial begin
        int nxt;
        int at;
        int q;
        bit found;

        // Reset state
        repeat (3) tick();
        check("rst_pwm", PWM, 0);
        check("rst_dir", DIR, 0);
        check("rst_e", E, 0);
        check("rst_fault", Fault, 0);
        check("rst_state", State, S_IDLE);

        // 1: Enable with Duty=4 -> RUN at first wrap, 40-cycle pulses
        RST    = 1'b0;
        Enable = 1'b1;
        repeat (PERIOD - 1) tick();
        check("idle_before_wrap", State, S_IDLE);
        check("idle_pwm", PWM, 0);
        tick();
        check("run_at_wrap", State, S_RUN);
        measure_period(4, -1, 0);
        check("dir_run", DIR, 0);

        // 2: Duty 4->12 at cnt=20 keeps the current pulse, next period widens
        measure_period(4, 19, 12);
        measure_period(12, -1, 0);

        // 3: direction change at cnt=50 with a brief SW7 glitch during dead time
        repeat (50) tick();
        dead_episode(1'b1, 1'b1);
        measure_period(12, -1, 0);

        // 4: overcurrent pulse in RUN
        repeat (10) tick();
        SnsA = 1'b1;
        repeat (4) tick();
        check("fault_pwm_off", PWM, 0);
        check("fault_state", State, S_FAULT);
        check("fault_flag", Fault, 1);
        tick();
        SnsA = 1'b0;
        repeat (200) tick();
        check("fault_hold_state", State, S_FAULT);
        check("fault_hold_flag", Fault, 1);
        check("fault_hold_pwm", PWM, 0);
        Enable = 1'b0;
        repeat (3) tick();
        check("fault_clear_state", State, S_IDLE);
        check("fault_clear_flag", Fault, 0);
        Enable = 1'b1;
        found = 0;
        for (int t = 0; t < 3 * PERIOD; t++) begin
            tick();
            if (State === 2'(S_RUN)) begin
                found = 1;
                break;
            end
        end
        check("rerun_seen", found, 1);
        check("rerun_at_wrap", n % PERIOD, 0);
        check("rerun_dir", DIR, 1);

        // 5: Duty=0 and Duty=15
        measure_period(12, 5, 0);
        measure_period(0, 5, 15);
        measure_period(15, 5, 15);
        cur = 15;

        // Random duty sequence with random change points
        for (int k = 0; k < 6; k++) begin
            nxt = $urandom_range(0, 15);
            at  = $urandom_range(0, 158);
            measure_period(cur, at, nxt);
            cur = nxt;
        end

        // 6: reset during DEAD at cnt=77
        repeat (10) tick();
        SW7 = 1'b0;
        found = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (State === 2'(S_DEAD)) begin
                found = 1;
                break;
            end
        end
        check("dead_for_reset", found, 1);
        for (int t = 0; t < PERIOD && (n % PERIOD) != 77; t++) tick();
        check("reset_point_cnt", n % PERIOD, 77);
        check("reset_point_state", State, S_DEAD);
        check("reset_point_dir", DIR, 1);
        RST = 1'b1;
        n   = 0;
        #1;
        check("async_rst_pwm", PWM, 0);
        check("async_rst_dir", DIR, 0);
        check("async_rst_e", E, 0);
        check("async_rst_fault", Fault, 0);
        check("async_rst_state", State, S_IDLE);
        repeat (3) tick();
        RST = 1'b0;
        repeat (PERIOD - 1) tick();
        check("restart_idle", State, S_IDLE);
        tick();
        check("restart_run", State, S_RUN);
        check("restart_dir", DIR, 0);
        measure_period(cur, -1, 0);

        // Random-phase direction change
        q = $urandom_range(1, 150);
        repeat (q) tick();
        dead_episode(1'b1, 1'b0);
        measure_period(cur, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
